rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, word width of the coefficient ROM data path.
REQ-002 Parameter N_REQ, fixed 4, number of requesters; not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester access request, bit i = requester i.
REQ-006 req_addr  input  8  packed ROM addresses, bits [2i+1:2i] = requester i.
REQ-007 gnt  output  4  one-hot grant, registered.
REQ-008 rsp_valid  output  4  one-hot response strobe, one cycle.
REQ-009 rsp_data  output  DATA_W  response word, registered.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.
REQ-011 rom_read_en  output  1  read enable to the coefficient ROM.
REQ-012 rom_addr  output  2  address to the coefficient ROM.
REQ-013 rom_val  input  DATA_W  ROM data, high-Z when rom_read_en is low.

Function
REQ-014 The FSM SHALL have states IDLE, READ and RESP, encoded in 2 bits; the unused encoding SHALL go to IDLE.
REQ-015 In IDLE with req != 0, the next edge SHALL select the winner, enter READ, set gnt to the winner's one-hot, and latch the winner's req_addr into rom_addr.
REQ-016 In IDLE with req == 0, the FSM SHALL stay in IDLE, and gnt, rsp_valid and rom_read_en SHALL be 0.
REQ-017 Arbitration SHALL be round-robin: search starts at pointer ptr (2 bits) and wraps 3->0; the first asserted req bit wins.
REQ-018 On each grant, ptr SHALL become (winner+1) mod 4.
REQ-019 rom_read_en SHALL be high exactly while in READ, decoded from state; rom_addr SHALL stay stable for the whole of READ.
REQ-020 The READ->RESP edge SHALL capture rom_val into rsp_data.
REQ-021 In RESP, rsp_valid SHALL equal gnt for exactly one cycle; the next edge SHALL enter IDLE and clear gnt.
REQ-022 Timing: req sampled at edge k; gnt and rom_read_en high from k+1; rsp_valid high k+2..k+3; next grant at the earliest at edge k+3.
REQ-023 Throughput SHALL be one access per 3 cycles when requests are back-to-back.
REQ-024 rsp_data SHALL hold its last captured value until the next capture; it SHALL NOT be sampled from the bus outside READ.
REQ-025 Any req or req_addr change after the grant edge SHALL be ignored until IDLE; a granted transaction always completes.
REQ-026 A requester whose req is still high in the IDLE cycle after its rsp_valid SHALL be treated as a new request, subject to round-robin order.
REQ-027 Address wrap: all 4 addresses are legal; no out-of-range case exists.
REQ-028 busy SHALL be high in READ and RESP, low in IDLE.

Reset
REQ-029 On assertion of rst_n=0, with no clock required, the block SHALL force: state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, rom_addr=0, ptr=0, rom_read_en=0, busy=0.
REQ-030 Reset in READ or RESP SHALL abort the transaction with no rsp_valid pulse; after release, arbitration SHALL restart from ptr=0.
REQ-031 The first grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-032 Single request: req=0001, addr0=2, ROM holds 0x3F19999A at address 2 -> gnt=0001 at k+1, rom_addr=2, rom_read_en=1; rsp_valid=0001 and rsp_data=0x3F19999A at k+2; IDLE at k+3.
REQ-033 All requesters held high with addresses 0,1,2,3 from reset -> grant order 0,1,2,3,0 at 3-cycle spacing; rsp_data sequence 0x3E4CCCCD, 0x3ECCCCCD, 0x3F19999A, 0x3F4CCCCD.
REQ-034 Pointer wrap: after a grant to requester 2 (ptr=3), req=1001 -> requester 3 granted first, then requester 0.
REQ-035 Requester 1 drops req and changes addr during READ -> rsp_valid=0010 still pulses with data from the originally latched address.
REQ-036 rst_n=0 during READ -> gnt, rom_read_en, busy and rsp_valid go 0 immediately and rsp_data=0; no rsp_valid pulse follows; after release with req=1100, requester 2 is granted first.
REQ-037 Idle bus: with req=0 for 10 cycles -> rom_read_en=0 throughout, rsp_data unchanged.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one coefficient ROM among 4 requesters
// ports: clk, rst_n (async, active-low); req/req_addr from requesters; gnt, rsp_valid, rsp_data back to them;
//        busy status; rom_read_en/rom_addr to the ROM, rom_val from it
module rom_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [7:0]        req_addr,
  output logic [3:0]        gnt,
  output logic [3:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              rom_read_en,
  output logic [1:0]        rom_addr,
  input  logic [DATA_W-1:0] rom_val
);
  localparam int N_REQ = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_t;
  state_t     state, nxt;
  logic [1:0] ptr, win, idx;
  logic       found;
  // first asserted request searching upward from ptr, wrapping 3->0
  always_comb begin
    win = ptr;
    idx = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // the unused encoding falls through to IDLE
  always_comb nxt = (state == IDLE) ? (found ? READ : IDLE) : (state == READ) ? RESP : IDLE;
  assign rom_read_en = state == READ;
  assign busy        = state != IDLE;
  assign rsp_valid   = (state == RESP) ? gnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      rsp_data <= '0;
      rom_addr <= '0;
      ptr      <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && found) begin
        gnt      <= 4'b1 << win;
        rom_addr <= req_addr[{win, 1'b0} +: 2];
        ptr      <= win + 2'd1;
      end else if (state != READ) gnt <= '0;
      // the bus is only driven during READ
      if (state == READ) rsp_data <= rom_val;
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: table, directed and random checks of rom_arbiter against a reference model
module tb_rom_arbiter;
  localparam int W = 32;
  logic         clk = 0, rst_n = 1;
  logic [3:0]   req = '0;
  logic [7:0]   req_addr = '0;
  logic [3:0]   gnt, rsp_valid;
  logic [W-1:0] rsp_data, rom_val;
  logic         busy, rom_read_en;
  logic [1:0]   rom_addr;
  logic [W-1:0] rom [4] = '{32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD};
  int errs = 0, checks = 0;

  rom_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .rom_read_en(rom_read_en), .rom_addr(rom_addr), .rom_val(rom_val)
  );

  assign rom_val = rom_read_en ? rom[rom_addr] : 'z;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   r;
    logic [7:0]   a;
    logic [3:0]   g;
    logic [1:0]   ra;
    logic [W-1:0] d;
  } vec_t;

  task automatic chk(string n, logic [W-1:0] a, logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[8];
    int mptr, w, ea;
    logic [3:0] r;
    logic [7:0] a;
    // sequence starts from ptr=0 after reset; ptr after each row: 1,2,1,3,0,1,1,2
    tbl[0] = '{4'b0001, 8'h02, 4'b0001, 2'd2, 32'h3F19999A};
    tbl[1] = '{4'b1111, 8'hE4, 4'b0010, 2'd1, 32'h3ECCCCCD};
    tbl[2] = '{4'b0001, 8'h03, 4'b0001, 2'd3, 32'h3F4CCCCD};
    tbl[3] = '{4'b0100, 8'hCF, 4'b0100, 2'd0, 32'h3E4CCCCD};
    tbl[4] = '{4'b1001, 8'h42, 4'b1000, 2'd1, 32'h3ECCCCCD};
    tbl[5] = '{4'b1001, 8'h42, 4'b0001, 2'd2, 32'h3F19999A};
    tbl[6] = '{4'b0000, 8'hFF, 4'b0000, 2'd0, 32'h3F19999A};
    tbl[7] = '{4'b1010, 8'h0C, 4'b0010, 2'd3, 32'h3F4CCCCD};

    // asynchronous reset with no clock edge
    #2 rst_n = 0;
    #1;
    chk("rst_gnt", W'(gnt), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_rd_en", W'(rom_read_en), 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_addr", W'(rom_addr), 0);
    chk("rst_valid", W'(rsp_valid), 0);
    step;
    rst_n = 1;

    foreach (tbl[i]) begin
      req = tbl[i].r;
      req_addr = tbl[i].a;
      step;
      chk($sformatf("tbl%0d_gnt", i), W'(gnt), W'(tbl[i].g));
      chk($sformatf("tbl%0d_busy", i), W'(busy), W'(|tbl[i].g));
      chk($sformatf("tbl%0d_rd_en", i), W'(rom_read_en), W'(|tbl[i].g));
      req = '0;
      req_addr = 8'($urandom);
      if (tbl[i].g != 0) begin
        chk($sformatf("tbl%0d_addr", i), W'(rom_addr), W'(tbl[i].ra));
        step;
        chk($sformatf("tbl%0d_valid", i), W'(rsp_valid), W'(tbl[i].g));
        chk($sformatf("tbl%0d_data", i), rsp_data, tbl[i].d);
        chk($sformatf("tbl%0d_rd_en_resp", i), W'(rom_read_en), 0);
        step;
        chk($sformatf("tbl%0d_idle_gnt", i), W'(gnt), 0);
        chk($sformatf("tbl%0d_idle_busy", i), W'(busy), 0);
        chk($sformatf("tbl%0d_idle_valid", i), W'(rsp_valid), 0);
      end else chk($sformatf("tbl%0d_hold", i), rsp_data, tbl[i].d);
    end

    // all requesters held from reset: grants 0,1,2,3,0 every 3 cycles
    rst_n = 0;
    req = 4'b1111;
    req_addr = 8'hE4;
    step;
    rst_n = 1;
    chk("rr_no_early_gnt", W'(gnt), 0);
    for (int t = 0; t < 5; t++) begin
      step;
      chk($sformatf("rr%0d_gnt", t), W'(gnt), W'(4'b1 << (t % 4)));
      chk($sformatf("rr%0d_addr", t), W'(rom_addr), W'(t % 4));
      step;
      chk($sformatf("rr%0d_valid", t), W'(rsp_valid), W'(4'b1 << (t % 4)));
      chk($sformatf("rr%0d_data", t), rsp_data, rom[t % 4]);
      step;
      chk($sformatf("rr%0d_idle", t), W'(gnt), 0);
    end
    req = '0;

    // requester 1 drops req and changes addr during READ (ptr is 1 here)
    req = 4'b0010;
    req_addr = 8'h04;
    step;
    chk("drop_gnt", W'(gnt), 4'b0010);
    req = '0;
    req_addr = 8'hFF;
    step;
    chk("drop_valid", W'(rsp_valid), 4'b0010);
    chk("drop_data", rsp_data, rom[1]);
    step;
    chk("drop_idle", W'(busy), 0);

    // reset during READ aborts; arbitration restarts from ptr=0
    req = 4'b0100;
    req_addr = 8'h30;
    step;
    chk("abort_gnt", W'(gnt), 4'b0100);
    chk("abort_rd_en", W'(rom_read_en), 1);
    #2 rst_n = 0;
    #1;
    chk("abort_gnt0", W'(gnt), 0);
    chk("abort_rd_en0", W'(rom_read_en), 0);
    chk("abort_busy0", W'(busy), 0);
    chk("abort_valid0", W'(rsp_valid), 0);
    chk("abort_data0", rsp_data, 0);
    req = 4'b1100;
    req_addr = 8'h30;
    step;
    chk("abort_no_pulse", W'(rsp_valid), 0);
    rst_n = 1;
    step;
    chk("abort_regnt", W'(gnt), 4'b0100);
    req = '0;
    step;
    chk("abort_data", rsp_data, rom[3]);
    step;

    // idle bus for 10 cycles
    for (int t = 0; t < 10; t++) begin
      step;
      chk("idle_rd_en", W'(rom_read_en), 0);
      chk("idle_data", rsp_data, rom[3]);
    end

    // random transactions against a round-robin model
    rst_n = 0;
    step;
    rst_n = 1;
    mptr = 0;
    for (int n = 0; n < 300; n++) begin
      r = 4'($urandom);
      a = 8'($urandom);
      req = r;
      req_addr = a;
      step;
      if (r == 0) begin
        chk("rnd_nogrant", W'(gnt), 0);
        chk("rnd_nobusy", W'(busy), 0);
      end else begin
        w = -1;
        for (int k = 0; k < 4; k++) if (w < 0 && r[(mptr + k) % 4]) w = (mptr + k) % 4;
        ea = int'(a[2 * w +: 2]);
        mptr = (w + 1) % 4;
        chk("rnd_gnt", W'(gnt), W'(4'b1 << w));
        chk("rnd_addr", W'(rom_addr), W'(ea));
        req = 4'($urandom);
        req_addr = 8'($urandom);
        step;
        chk("rnd_valid", W'(rsp_valid), W'(4'b1 << w));
        chk("rnd_data", rsp_data, rom[ea]);
        step;
        chk("rnd_idle", W'(gnt), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
